sync_test_sequencer: RTL and testbench

- Single-clock (clk) self-test sequencer for the synchronizer demo datapath.
- Generates a series of N-bit test words, loads them into the source register, fires the strobe/pulse needed by the selected synchronizer, and selects that synchronizer's output on the mux.
- Checks the word returned from the clk_2 domain, measures latency and counts failures.
- Replaces manual switch/trigger operation of the synchronizer blocks.

---
 rtl/sync_test_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_sync_test_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_test_sequencer.sv
// Self-test sequencer for the synchronizer demo: drives test words, fires the strobe or pulse
// the selected synchronizer needs, and checks the word returned from the clk_2 domain.
// Optional per-run latency extremes are enabled by defining SYNC_SEQ_MINMAX_EN.
module sync_test_sequencer #(
    parameter int           N       = 8,
    parameter logic [N-1:0] STEP    = N'(8'h5B),
    parameter int           TIMEOUT = 255,
    parameter int           STABLE  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [1:0]   mode,
    input  logic [N-1:0] seed,
    input  logic [7:0]   num_words,
    input  logic [N-1:0] rx_data,
    output logic [N-1:0] tx_data,
    output logic         tx_load,
    output logic         stb,
    output logic         pulse,
    output logic [2:0]   sel,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [7:0]   err_count,
    output logic [7:0]   last_latency,
    output logic [7:0]   min_latency,
    output logic [7:0]   max_latency
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0] STABLE_C  = 8'(STABLE);
    localparam logic [7:0] STABLE_M1 = 8'(STABLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t       state;
    logic [1:0]   mode_q;
    logic [7:0]   num_q;
    logic [N-1:0] pattern;
    logic [7:0]   word_cnt;
    logic [7:0]   lat_cnt;
    logic [7:0]   match_cnt;
    logic [N-1:0] rx_meta;
    logic [N-1:0] rx_sync;

    logic [7:0]   lat_next;
    logic [7:0]   match_next;
    logic [7:0]   word_next;
    logic [7:0]   latency;
    logic         word_ok;
    logic         word_late;
    logic         start_run;

    function automatic logic [2:0] sel_of(input logic [1:0] m);
        case (m)
            2'd0:    return 3'd2;
            2'd1:    return 3'd3;
            2'd2:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Per-bit resync only; a multi-bit word is trusted once it has been seen STABLE times in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= '0;
            rx_sync <= '0;
        end else begin
            rx_meta <= rx_data;
            rx_sync <= rx_meta;
        end
    end

    always_comb begin
        lat_next   = lat_cnt + 8'd1;
        match_next = (rx_sync == pattern) ? match_cnt + 8'd1 : 8'd0;
        word_ok    = (match_next == STABLE_C);
        word_late  = (lat_next == TIMEOUT_C);
        latency    = lat_next - STABLE_M1;
        word_next  = word_cnt + 8'd1;
        start_run  = (state == S_IDLE) && start && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            mode_q       <= '0;
            num_q        <= '0;
            pattern      <= '0;
            word_cnt     <= '0;
            lat_cnt      <= '0;
            match_cnt    <= '0;
            tx_data      <= '0;
            tx_load      <= 1'b0;
            stb          <= 1'b0;
            pulse        <= 1'b0;
            sel          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            last_latency <= '0;
        end else begin
            // NOTE: one-cycle outputs default low here and are raised only by their state; all
            // state uses <= so every branch sees the values from before this edge.
            tx_load <= 1'b0;
            stb     <= 1'b0;
            pulse   <= 1'b0;
            done    <= 1'b0;

            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_run) begin
                            mode_q       <= mode;
                            num_q        <= num_words;
                            pattern      <= seed;
                            word_cnt     <= '0;
                            err_count    <= '0;
                            last_latency <= '0;
                            pass         <= 1'b0;
                            busy         <= 1'b1;
                            sel          <= sel_of(mode);
                            state        <= (num_words == 8'd0) ? S_DONE : S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        tx_data <= pattern;
                        tx_load <= 1'b1;
                        state   <= S_LAUNCH;
                    end
                    S_LAUNCH: begin
                        stb       <= (mode_q == 2'd1);
                        pulse     <= (mode_q == 2'd2);
                        lat_cnt   <= '0;
                        match_cnt <= '0;
                        state     <= S_WAIT;
                    end
                    S_WAIT: begin
                        lat_cnt   <= lat_next;
                        match_cnt <= match_next;
                        // A match on the timeout cycle still counts as a match.
                        if (word_ok) begin
                            last_latency <= latency;
                            state        <= S_NEXT;
                        end else if (word_late) begin
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                            state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        pattern  <= pattern + STEP;
                        word_cnt <= word_next;
                        state    <= (word_next == num_q) ? S_DONE : S_LOAD;
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        pass  <= (err_count == 8'd0);
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef SYNC_SEQ_MINMAX_EN
    logic accept_word;
    assign accept_word = (state == S_WAIT) && !abort && word_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_latency <= 8'hFF;
            max_latency <= '0;
        end else if (start_run) begin
            min_latency <= 8'hFF;
            max_latency <= '0;
        end else if (accept_word) begin
            if (latency < min_latency) min_latency <= latency;
            if (latency > max_latency) max_latency <= latency;
        end
    end
`else
    assign min_latency = '0;
    assign max_latency = '0;
`endif

endmodule

// File: tb/tb_sync_test_sequencer.sv
// Directed bench for sync_test_sequencer: table-driven loopback runs plus hand-written
// timeout, glitch, abort, min/max and reset-mid-run sequences.
module tb_sync_test_sequencer;

    localparam logic [7:0] STEP = 8'h5B;
`ifdef SYNC_SEQ_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode = '0;
    logic [7:0] seed = '0;
    logic [7:0] num_words = '0;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_load, stb, pulse, busy, done, pass;
    logic [2:0] sel;
    logic [7:0] err_count, last_latency, min_latency, max_latency;

    int n_tests = 0;
    int n_fail  = 0;

    sync_test_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .seed(seed), .num_words(num_words), .rx_data(rx_data), .tx_data(tx_data),
        .tx_load(tx_load), .stb(stb), .pulse(pulse), .sel(sel), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count), .last_latency(last_latency),
        .min_latency(min_latency), .max_latency(max_latency)
    );

    always #5 clk = ~clk;

    // Loopback: rx_data is tx_data delayed by 'tap' clk cycles, or a forced value.
    logic [7:0] pipe [16];
    int         tap = 4;
    int         tap_sched [8];
    logic       rx_force = 1'b0;
    logic [7:0] rx_drive = '0;

    initial for (int i = 0; i < 16; i++) pipe[i] = '0;
    always @(posedge clk) begin
        pipe[0] <= tx_data;
        for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
    assign rx_data = rx_force ? rx_drive : pipe[tap-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Results of the last run() call.
    int         r_cycles, r_loads, r_stbs, r_pulses, r_load_cyc, r_strobe_cyc;
    bit         r_done;
    logic [7:0] tx_log [8];

    task automatic run(input logic [1:0] m, input logic [7:0] sd, input logic [7:0] nw);
        mode = m; seed = sd; num_words = nw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_cycles = 1; r_loads = 0; r_stbs = 0; r_pulses = 0;
        r_load_cyc = -1; r_strobe_cyc = -1; r_done = 1'b0;
        while (!r_done && r_cycles < 3000) begin
            if (tx_load) begin
                if (r_loads < 8) begin
                    tx_log[r_loads] = tx_data;
                    tap = tap_sched[r_loads];
                end
                r_loads++;
                r_load_cyc = r_cycles;
            end
            if (stb)   begin r_stbs++;   r_strobe_cyc = r_cycles; end
            if (pulse) begin r_pulses++; r_strobe_cyc = r_cycles; end
            if (done) r_done = 1'b1;
            else begin
                @(negedge clk);
                r_cycles++;
            end
        end
        check("run_done_seen", 32'(r_done), 32'd1);
    endtask

    task automatic check_tx_log(input logic [7:0] sd);
        logic [7:0] w;
        w = sd;
        for (int i = 0; i < r_loads && i < 8; i++) begin
            check($sformatf("tx_word%0d", i), 32'(tx_log[i]), 32'(w));
            w = w + STEP;
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] seed;
        logic [7:0] nw;
        logic [2:0] sel;
        int         loads, stbs, pulses, cycles;
        logic [7:0] lat, err, mn, mx;
        logic       pass;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int   cnt;
        bit   seen;
        logic [7:0] pat;

        for (int i = 0; i < 8; i++) tap_sched[i] = 4;
        // Loopback delay 4 + 2 resync flops: latency 6 whenever the word differs from the last one.
        vecs[0] = '{2'd0, 8'h00, 8'd3, 3'd2, 3, 0, 0, 30, 8'd6, 8'd0,
                    MINMAX ? 8'd1 : 8'd0, MINMAX ? 8'd6 : 8'd0, 1'b1};
        vecs[1] = '{2'd1, 8'h10, 8'd1, 3'd3, 1, 1, 0, 13, 8'd6, 8'd0,
                    MINMAX ? 8'd6 : 8'd0, MINMAX ? 8'd6 : 8'd0, 1'b1};
        vecs[2] = '{2'd2, 8'h20, 8'd2, 3'd4, 2, 0, 2, 24, 8'd6, 8'd0,
                    MINMAX ? 8'd6 : 8'd0, MINMAX ? 8'd6 : 8'd0, 1'b1};
        vecs[3] = '{2'd3, 8'hF0, 8'd1, 3'd1, 1, 0, 0, 13, 8'd6, 8'd0,
                    MINMAX ? 8'd6 : 8'd0, MINMAX ? 8'd6 : 8'd0, 1'b1};
        vecs[4] = '{2'd0, 8'h40, 8'd0, 3'd2, 0, 0, 0, 2, 8'd0, 8'd0,
                    MINMAX ? 8'hFF : 8'd0, 8'd0, 1'b1};

        // Reset state
        #12;
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_pulses", 32'({tx_load, stb, pulse, busy, done, pass}), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_last_lat", 32'(last_latency), 32'd0);
        check("rst_min", 32'(min_latency), MINMAX ? 32'hFF : 32'd0);
        check("rst_max", 32'(max_latency), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run(vecs[v].mode, vecs[v].seed, vecs[v].nw);
            check($sformatf("v%0d_cycles", v), 32'(r_cycles), 32'(vecs[v].cycles));
            check($sformatf("v%0d_loads", v), 32'(r_loads), 32'(vecs[v].loads));
            check($sformatf("v%0d_stbs", v), 32'(r_stbs), 32'(vecs[v].stbs));
            check($sformatf("v%0d_pulses", v), 32'(r_pulses), 32'(vecs[v].pulses));
            check($sformatf("v%0d_sel", v), 32'(sel), 32'(vecs[v].sel));
            check($sformatf("v%0d_pass", v), 32'(pass), 32'(vecs[v].pass));
            check($sformatf("v%0d_err", v), 32'(err_count), 32'(vecs[v].err));
            check($sformatf("v%0d_last_lat", v), 32'(last_latency), 32'(vecs[v].lat));
            check($sformatf("v%0d_min", v), 32'(min_latency), 32'(vecs[v].mn));
            check($sformatf("v%0d_max", v), 32'(max_latency), 32'(vecs[v].mx));
            check($sformatf("v%0d_busy_at_done", v), 32'(busy), 32'd0);
            if (vecs[v].stbs + vecs[v].pulses > 0)
                check($sformatf("v%0d_strobe_after_load", v), 32'(r_strobe_cyc), 32'(r_load_cyc + 1));
            check_tx_log(vecs[v].seed);
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", v), 32'(done), 32'd0);
        end

        // Stuck rx: every word times out after 255 wait cycles.
        rx_force = 1'b1; rx_drive = 8'hAA;
        run(2'd0, 8'h00, 8'd2);
        check("to_cycles", 32'(r_cycles), 32'd518);
        check("to_err", 32'(err_count), 32'd2);
        check("to_pass", 32'(pass), 32'd0);
        check("to_last_lat", 32'(last_latency), 32'd0);
        @(negedge clk);

        // Two-cycle glitch to the pattern is rejected; the later stable run gives latency 10.
        pat = 8'h33;
        mode = 2'd1; seed = pat; num_words = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!stb && cnt < 20) begin @(negedge clk); cnt++; end
        check("gl_stb_seen", 32'(stb), 32'd1);
        seen = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            rx_drive = (c == 3 || c == 4 || c >= 8) ? pat : 8'hAA;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("gl_done", 32'(seen), 32'd1);
        check("gl_latency", 32'(last_latency), 32'd10);
        check("gl_err", 32'(err_count), 32'd0);

        // Abort mid-WAIT after one timeout, then a clean run.
        rx_drive = 8'hAA;
        mode = 2'd0; seed = 8'h00; num_words = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (err_count != 8'd1 && cnt < 600) begin @(negedge clk); cnt++; end
        check("ab_first_timeout", 32'(err_count), 32'd1);
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy_low", 32'(busy), 32'd0);
        check("ab_err_frozen", 32'(err_count), 32'd1);
        check("ab_pass", 32'(pass), 32'd0);
        seen = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) seen = 1'b1;
            if (tx_load) cnt++;
            @(negedge clk);
        end
        check("ab_no_done", 32'(seen), 32'd0);
        check("ab_no_load", 32'(cnt), 32'd0);
        rx_force = 1'b0;
        run(2'd0, 8'h77, 8'd1);
        check("ab_rerun_err", 32'(err_count), 32'd0);
        check("ab_rerun_pass", 32'(pass), 32'd1);
        check("ab_rerun_cycles", 32'(r_cycles), 32'd13);
        @(negedge clk);

        // start together with abort in IDLE is ignored.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (done || tx_load) seen = 1'b1;
            @(negedge clk);
        end
        check("sa_idle", 32'(seen), 32'd0);

        // Per-word loopback delays 3, 7, 5 give latencies 5, 9, 7.
        tap_sched[0] = 3; tap_sched[1] = 7; tap_sched[2] = 5;
        run(2'd0, 8'h01, 8'd3);
        check("mm_cycles", 32'(r_cycles), 32'd38);
        check("mm_last_lat", 32'(last_latency), 32'd7);
        check("mm_min", 32'(min_latency), MINMAX ? 32'd5 : 32'd0);
        check("mm_max", 32'(max_latency), MINMAX ? 32'd9 : 32'd0);
        check("mm_pass", 32'(pass), 32'd1);
        for (int i = 0; i < 8; i++) tap_sched[i] = 4;
        tap = 4;
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        mode = 2'd1; seed = 8'h99; num_words = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mr_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_sel", 32'(sel), 32'd0);
        check("mr_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        check("mr_stays_idle", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
